mem_wb: RTL
===========

Name: mem_wb

Overview:
- Receiving end of the EX→WB interface of the 3-stage pipeline.
- Consumes the execute stage's registered wb_* outputs and performs data-memory loads and stores over a ready/valid bus.
- Extracts and extends sub-word load data, then drives the register-file write port.
- Generates stall_read back to execute while a memory access is outstanding, and returns the branch flags as wb_branch_i / wb_branch_nxt_i.

Parameters:
- TIMEOUT_CYCLES, 64, maximum cycles to wait on dmem_ready or dmem_rvalid (used only with MEM_WB_TIMEOUT_EN).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- wb_result  input  32  ALU result, or effective memory address for memory ops.
- wb_store_data  input  32  rs2 data for stores.
- wb_mem_write  input  1  store instruction.
- wb_mem_to_reg  input  1  load instruction.
- wb_alu_to_reg  input  1  ALU/jump result writes rd.
- wb_dest_reg_sel  input  5  rd.
- wb_read_address  input  2  byte offset, equal to wb_result[1:0].
- mem_alu_operation  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- wb_branch, wb_branch_nxt  input  1 each  branch flags from execute.
- dmem_req  output  1  memory request valid.
- dmem_we  output  1  1 = store.
- dmem_addr  output  32  word-aligned address, {wb_result[31:2],2'b00}.
- dmem_wdata  output  32  lane-replicated store data.
- dmem_wstrb  output  4  byte strobes.
- dmem_ready  input  1  request accepted.
- dmem_rvalid  input  1  load data valid.
- dmem_rdata  input  32  load data word.
- stall_read  output  1  holds the execute stage.
- wb_branch_i, wb_branch_nxt_i  output  1 each  registered branch flags back to execute.
- rf_we  output  1  register-file write enable.
- rf_waddr  output  5  register-file write address.
- rf_wdata  output  32  register-file write data.
- misaligned  output  1  one-cycle pulse on a misaligned access.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM enters IDLE.
  - All outputs go to 0, including stall_read, rf_we, dmem_req, misaligned and the branch flags.
  - An outstanding request is dropped. After reset release, a late dmem_rvalid is ignored.
- Input sampling: inputs are sampled only in IDLE with stall_read=0. Execute holds its outputs stable while stall_read=1.
- FSM states: IDLE, REQ, RESP.
- IDLE, ALU op (wb_alu_to_reg=1):
  - Next cycle: rf_we=1, rf_waddr=rd, rf_wdata=wb_result.
  - Latency is 1 cycle and there is no stall.
- IDLE, load:
  - Registers op, address and rd; drives dmem_req=1, dmem_we=0; goes to REQ.
  - stall_read=1 from the next cycle until the writeback cycle.
- IDLE, store:
  - Drives dmem_req=1, dmem_we=1; goes to REQ; stall_read=1.
- REQ:
  - dmem_req and address/data are held stable until dmem_ready=1.
  - On ready, a store returns to IDLE and stall_read drops next cycle.
  - On ready, a load goes to RESP and dmem_req drops.
- RESP:
  - On dmem_rvalid, the selected lane is extracted: byte = rdata >> (8*offset); half = rdata >> (16*offset[1]).
  - Extension: B and H sign-extend; BU and HU zero-extend; W passes through.
  - Next cycle: rf_we=1, rf_wdata=extracted value; FSM returns to IDLE; stall_read deasserts in the same cycle.
- Store lanes:
  - SB: wdata={4{b}}, wstrb=0001<<offset.
  - SH: wdata={2{h}}, wstrb=0011<<(2*offset[1]).
  - SW: wstrb=1111.
- Misalignment:
  - Condition: H with offset[0]=1, or W with offset≠0.
  - Response: no dmem_req, no rf write, misaligned=1 for one cycle, no stall.
- x0: rd=0 forces rf_we=0; all other behaviour is unchanged.
- Simultaneous flags: wb_mem_to_reg and wb_mem_write both set → the load wins.
- Branch flags: wb_branch_i and wb_branch_nxt_i are the wb_branch / wb_branch_nxt inputs registered by one cycle. They are frozen while stall_read=1.
- dmem_rvalid arriving in IDLE or REQ is ignored.

Optional Feature:
- Macro: MEM_WB_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ and RESP and clears on state entry.
  - When it reaches TIMEOUT_CYCLES, the access is aborted and the FSM returns to IDLE.
  - bus_error (an extra 1-bit output port) pulses for one cycle and no rf write occurs.
  - stall_read deasserts the following cycle.
- Undefined: no counter and no bus_error port; the FSM waits indefinitely.

Test Plan:
- ALU op, wb_result=0x1234, rd=5 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, stall_read=0.
- LB at address 0x103, dmem_ready after 2 cycles, rdata=0x80AABBCC, rvalid 1 cycle later → rf_wdata=0xFFFFFF80; stall_read high throughout the access.
- LHU at address 0x102, rdata=0x9ABC1234 → rf_wdata=0x00009ABC. LW at address 0x101 → misaligned pulse, no dmem_req, rf_we=0.
- SB at address 0x102, store data 0x000000A5 → dmem_we=1, wstrb=0100, wdata=0xA5A5A5A5; dmem_addr=0x100 held stable until ready.
- Load to rd=0 → no rf_we. Reset asserted in RESP → all outputs 0 immediately; a later rvalid produces no write.
- With MEM_WB_TIMEOUT_EN and TIMEOUT_CYCLES=4, no dmem_ready → bus_error pulse after 4 cycles in REQ; FSM returns to IDLE; stall_read=0 the next cycle.

Source files
------------

// File: rtl/mem_wb.sv
// Writeback stage: load/store over a ready/valid data bus plus the register-file write port. ALU results are written 1 cycle after sampling.
// Memory ops hold execute via stall_read until writeback; MEM_WB_TIMEOUT_EN adds an abort counter and a bus_error output.
module mem_wb #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_result,
  input  logic [31:0] wb_store_data,
  input  logic        wb_mem_write,
  input  logic        wb_mem_to_reg,
  input  logic        wb_alu_to_reg,
  input  logic [4:0]  wb_dest_reg_sel,
  input  logic [1:0]  wb_read_address,
  input  logic [2:0]  mem_alu_operation,
  input  logic        wb_branch,
  input  logic        wb_branch_nxt,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall_read,
  output logic        wb_branch_i,
  output logic        wb_branch_nxt_i,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
`ifdef MEM_WB_TIMEOUT_EN
  output logic        bus_error,
`endif
  output logic        misaligned
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        is_mem, is_store, mis;
  logic [31:0] st_wdata, byte_sh, half_sh, ld_data;
  logic [3:0]  st_wstrb;
  logic        timeout;
  logic        unused_addr_lsbs;

  // Byte offset arrives separately on wb_read_address.
  assign unused_addr_lsbs = ^wb_result[1:0];

  assign is_mem   = wb_mem_to_reg | wb_mem_write;
  assign is_store = wb_mem_write & ~wb_mem_to_reg;

  always_comb begin
    mis = 1'b0;
    case (mem_alu_operation[1:0])
      2'b01:   mis = wb_read_address[0];
      2'b10:   mis = |wb_read_address;
      default: mis = 1'b0;
    endcase
  end

  always_comb begin
    st_wdata = wb_store_data;
    st_wstrb = 4'b1111;
    case (mem_alu_operation[1:0])
      2'b00: begin
        st_wdata = {4{wb_store_data[7:0]}};
        st_wstrb = 4'b0001 << wb_read_address;
      end
      2'b01: begin
        st_wdata = {2{wb_store_data[15:0]}};
        st_wstrb = 4'b0011 << {wb_read_address[1], 1'b0};
      end
      default: ;
    endcase
  end

  assign byte_sh = dmem_rdata >> {off_q, 3'b000};
  assign half_sh = dmem_rdata >> {off_q[1], 4'b0000};

  always_comb begin
    ld_data = dmem_rdata;
    case (op_q)
      3'b000:  ld_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b001:  ld_data = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b100:  ld_data = {24'h0, byte_sh[7:0]};
      3'b101:  ld_data = {16'h0, half_sh[15:0]};
      default: ld_data = dmem_rdata;
    endcase
  end

`ifdef MEM_WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
`endif

  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    case (state)
      IDLE:    if (is_mem && !mis) state_nxt = REQ;
      REQ:     if (dmem_ready) state_nxt = we_q ? IDLE : RESP;
      RESP:    if (dmem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
`ifdef MEM_WB_TIMEOUT_EN
    // Abort only when the bus made no progress in the final allowed cycle.
    timeout = (state != IDLE) && (state_nxt == state) &&
              (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    if (timeout) state_nxt = IDLE;
`endif
  end

  assign dmem_req   = (state == REQ);
  assign dmem_we    = dmem_req & we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = wstrb_q;
  assign stall_read = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      op_q            <= 3'b0;
      off_q           <= 2'b0;
      rd_q            <= 5'b0;
      we_q            <= 1'b0;
      addr_q          <= 32'b0;
      wdata_q         <= 32'b0;
      wstrb_q         <= 4'b0;
      rf_we           <= 1'b0;
      rf_waddr        <= 5'b0;
      rf_wdata        <= 32'b0;
      misaligned      <= 1'b0;
      wb_branch_i     <= 1'b0;
      wb_branch_nxt_i <= 1'b0;
    end else begin
      state      <= state_nxt;
      rf_we      <= 1'b0;
      misaligned <= 1'b0;
      if (state == IDLE) begin
        wb_branch_i     <= wb_branch;
        wb_branch_nxt_i <= wb_branch_nxt;
        if (is_mem) begin
          if (mis) begin
            misaligned <= 1'b1;
          end else begin
            op_q    <= mem_alu_operation;
            off_q   <= wb_read_address;
            rd_q    <= wb_dest_reg_sel;
            we_q    <= is_store;
            addr_q  <= {wb_result[31:2], 2'b00};
            wdata_q <= st_wdata;
            wstrb_q <= is_store ? st_wstrb : 4'b0000;
          end
        end else if (wb_alu_to_reg) begin
          rf_we    <= |wb_dest_reg_sel;
          rf_waddr <= wb_dest_reg_sel;
          rf_wdata <= wb_result;
        end
      end else if (state == RESP && dmem_rvalid && !timeout) begin
        rf_we    <= |rd_q;
        rf_waddr <= rd_q;
        rf_wdata <= ld_data;
      end
    end
  end

`ifdef MEM_WB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      bus_error <= 1'b0;
    end else begin
      bus_error <= timeout;
      if (state == IDLE || state_nxt != state) cnt <= '0;
      else                                     cnt <= cnt + 1'b1;
    end
  end
`endif

endmodule
